// File: rtl/nl2_cln_cfifo.sv
// nl2_cln_cfifo: pointer-based circular FIFO for L2 cleanup request paths.
// Supports any DEPTH >= 2 without data shifting. Also provides an occupancy
// count, full/almost-empty thresholds, a synchronous flush, sticky
// overflow/underflow flags and a peak-occupancy monitor.
module nl2_cln_cfifo #(
  parameter int WIDTH           = 1,
  parameter int DEPTH           = 2,
  parameter int FULL_THRESHOLD  = 1,
  parameter int EMPTY_THRESHOLD = 1,
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic [WIDTH-1:0] fifo_in,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  output logic             fifo_full,
  output logic             fifo_almost_empty,
  output logic             fifo_head_valid,
  output logic [WIDTH-1:0] fifo_head_data,
  output logic [CW-1:0]    fifo_count,
  output logic [CW-1:0]    fifo_peak,
  output logic             fifo_ovf,
  output logic             fifo_unf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_LIMIT  = CW'(DEPTH - FULL_THRESHOLD);
  localparam logic [CW-1:0] EMPTY_LIMIT = CW'(EMPTY_THRESHOLD);
  localparam logic [PW-1:0] PTR_LAST    = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    peak_q, peak_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic pop_acc;
  logic push_acc;
  logic ovf_set;
  logic unf_set;

  // Accept/drop decisions; a pop at full frees the slot the push needs,
  // and flush suppresses every push/pop side effect for its cycle.
  always_comb begin
    pop_acc  = pop & (count_q != '0);
    push_acc = push & ((count_q != DEPTH_C) | pop_acc);
    ovf_set  = ~flush & push & ~push_acc;
    unf_set  = ~flush & pop & (count_q == '0);
  end

  // Next-state for storage, pointers, occupancy and monitor flags.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Vacated slots are zeroed so an empty FIFO always presents zero
      // data; a same-cycle push into that slot overrides the clear.
      if (pop_acc) begin
        mem_d[rd_ptr_q] = '0;
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_acc) begin
        mem_d[wr_ptr_q] = fifo_in;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (push_acc && !pop_acc) begin
        count_d = count_q + 1'b1;
      end else if (!push_acc && pop_acc) begin
        count_d = count_q - 1'b1;
      end
    end

    // err_clr restarts the peak from the new occupancy; otherwise track max.
    if (err_clr) begin
      peak_d = count_d;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end

    // A new error event in the clearing cycle still leaves the flag set.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  // State registers with asynchronous reset discarding all contents.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Outputs depend only on registered state, never on this cycle's inputs.
  always_comb begin
    fifo_full         = count_q > FULL_LIMIT;
    fifo_almost_empty = count_q < EMPTY_LIMIT;
    fifo_head_valid   = count_q != '0;
    fifo_head_data    = fifo_head_valid ? mem_q[rd_ptr_q] : '0;
    fifo_count        = count_q;
    fifo_peak         = peak_q;
    fifo_ovf          = ovf_q;
    fifo_unf          = unf_q;
  end

endmodule

// File: tb/tb_nl2_cln_cfifo.sv
// Testbench for nl2_cln_cfifo (DEPTH=5, WIDTH=8, FULL_THRESHOLD=2,
// EMPTY_THRESHOLD=2). A queue-based reference model tracks expected contents
// and flags; directed steps cover the main scenarios, then random traffic.
module tb_nl2_cln_cfifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int FT    = 2;
  localparam int ET    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_a;
  logic [WIDTH-1:0] fifo_in;
  logic             push;
  logic             pop;
  logic             flush;
  logic             err_clr;
  logic             fifo_full;
  logic             fifo_almost_empty;
  logic             fifo_head_valid;
  logic [WIDTH-1:0] fifo_head_data;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    fifo_peak;
  logic             fifo_ovf;
  logic             fifo_unf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [WIDTH-1:0] model_q[$];
  int               model_peak;
  logic             model_ovf;
  logic             model_unf;

  nl2_cln_cfifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .FULL_THRESHOLD(FT),
    .EMPTY_THRESHOLD(ET)
  ) dut (
    .clk(clk),
    .rst_a(rst_a),
    .fifo_in(fifo_in),
    .push(push),
    .pop(pop),
    .flush(flush),
    .err_clr(err_clr),
    .fifo_full(fifo_full),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_head_valid(fifo_head_valid),
    .fifo_head_data(fifo_head_data),
    .fifo_count(fifo_count),
    .fifo_peak(fifo_peak),
    .fifo_ovf(fifo_ovf),
    .fifo_unf(fifo_unf)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_peak = 0;
    model_ovf  = 1'b0;
    model_unf  = 1'b0;
  endtask

  // Behavioural rules applied at one clock edge, using pre-edge occupancy.
  task automatic modelStep(input logic p_push, input logic p_pop, input logic p_flush,
                           input logic p_clr, input logic [WIDTH-1:0] p_data);
    int  n;
    bit  pop_ok;
    bit  push_ok;
    n = model_q.size();
    if (p_clr) begin
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end
    if (p_flush) begin
      model_q.delete();
    end else begin
      pop_ok  = p_pop && (n > 0);
      push_ok = p_push && ((n < DEPTH) || pop_ok);
      if (p_pop && n == 0) model_unf = 1'b1;
      if (p_push && !push_ok) model_ovf = 1'b1;
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) model_q.push_back(p_data);
    end
    if (p_clr) model_peak = model_q.size();
    else if (model_q.size() > model_peak) model_peak = model_q.size();
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = model_q.size();
    checkVal({tag, ".count"}, 32'(fifo_count), 32'(n));
    checkVal({tag, ".valid"}, 32'(fifo_head_valid), 32'(n != 0));
    checkVal({tag, ".head"}, 32'(fifo_head_data), (n != 0) ? 32'(model_q[0]) : 32'd0);
    checkVal({tag, ".full"}, 32'(fifo_full), 32'(n > DEPTH - FT));
    checkVal({tag, ".aempty"}, 32'(fifo_almost_empty), 32'(n < ET));
    checkVal({tag, ".peak"}, 32'(fifo_peak), 32'(model_peak));
    checkVal({tag, ".ovf"}, 32'(fifo_ovf), 32'(model_ovf));
    checkVal({tag, ".unf"}, 32'(fifo_unf), 32'(model_unf));
  endtask

  // Drive one cycle of inputs, clock it, then check #1 after the edge.
  task automatic applyStimulus(input string tag, input logic p_push, input logic p_pop,
                               input logic p_flush, input logic p_clr,
                               input logic [WIDTH-1:0] p_data);
    push    = p_push;
    pop     = p_pop;
    flush   = p_flush;
    err_clr = p_clr;
    fifo_in = p_data;
    @(posedge clk);
    modelStep(p_push, p_pop, p_flush, p_clr, p_data);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    fifo_in = '0;
    rst_a   = 1'b1;
    modelReset();
    #2;
    checkOutput("reset");
    checkVal("reset.aempty_lit", 32'(fifo_almost_empty), 32'd1);
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    // Fill 0x11..0x15; full rises at count 4
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus("fill", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h11 + i));
    end
    checkVal("fill.count5", 32'(fifo_count), 32'd5);
    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      checkVal("drain.order", 32'(fifo_head_data), 32'(8'h11 + i));
      applyStimulus("drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    checkVal("drain.zero", 32'(fifo_head_data), 32'd0);

    // Wrap: prefill 3 then 12 cycles of push+pop
    for (int i = 0; i < 3; i++) applyStimulus("prefill", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h20 + i));
    for (int i = 0; i < 12; i++) applyStimulus("wrap", 1'b1, 1'b1, 1'b0, 1'b0, WIDTH'(8'h30 + i));
    checkVal("wrap.count3", 32'(fifo_count), 32'd3);

    // Boundaries
    for (int i = 0; i < 2; i++) applyStimulus("tofull", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h40 + i));
    applyStimulus("ovf", 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    checkVal("ovf.flag", 32'(fifo_ovf), 32'd1);
    applyStimulus("fullpp", 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    applyStimulus("clr1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) applyStimulus("empty", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus("unf", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkVal("unf.flag", 32'(fifo_unf), 32'd1);
    applyStimulus("clr2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("emptypp", 1'b1, 1'b1, 1'b0, 1'b0, 8'h66);
    checkVal("emptypp.count1", 32'(fifo_count), 32'd1);

    // Flush at count 3 with push+pop
    for (int i = 0; i < 2; i++) applyStimulus("preflush", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h70 + i));
    applyStimulus("clr3", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("flush", 1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
    checkVal("flush.count0", 32'(fifo_count), 32'd0);
    applyStimulus("postflush", 1'b1, 1'b0, 1'b0, 1'b0, 8'h78);

    // Peak / err_clr
    applyStimulus("clr4", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus("pk_fill", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h80 + i));
    for (int i = 0; i < 3; i++) applyStimulus("pk_drain", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkVal("peak.4", 32'(fifo_peak), 32'd4);
    applyStimulus("pk_clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    checkVal("peak.clr", 32'(fifo_peak), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus("pk_refill", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'h90 + i));
    applyStimulus("clr_ovf", 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
    checkVal("clr_ovf.flag", 32'(fifo_ovf), 32'd1);

    // Asynchronous reset mid-burst at count 3
    applyStimulus("prerst_flush", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus("burst", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(8'hA0 + i));
    push    = 1'b1;
    fifo_in = 8'hAF;
    #2;
    rst_a = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst");
    push = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    checkOutput("after_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(99) < 55),
                    1'($urandom_range(99) < 50),
                    1'($urandom_range(99) < 3),
                    1'($urandom_range(99) < 5),
                    WIDTH'($urandom_range(255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
